// File: rtl/dlx_pkg.sv
// Shared DLX encodings: ALU operations, second-operand selects, opcodes/func codes
// and the control FSM state enum. DLX_ALU imports the same ALUop/s2op constants.
package dlx_pkg;

  typedef enum logic [4:0] {
    ALU_ADD = 5'b00000,
    ALU_SUB = 5'b00001,
    ALU_AND = 5'b00010,
    ALU_OR  = 5'b00011,
    ALU_XOR = 5'b00100,
    ALU_SLL = 5'b00101,
    ALU_SRL = 5'b00110,
    ALU_CMP = 5'b10000
  } aluop_t;

  typedef enum logic [2:0] {
    S2_RT   = 3'b000,
    S2_ZERO = 3'b001,
    S2_SIMM = 3'b011,
    S2_ZIMM = 3'b100
  } s2op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_TRAP  = 6'h11;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h04;
  localparam logic [5:0] FN_SRL = 6'h06;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

endpackage

// File: rtl/dlx_alu_decode.sv
// Combinational opcode/func decode to ALU controls plus a legality flag.
// TRAP is reported as not legal so the FSM can treat it like an illegal encoding.
module dlx_alu_decode
  import dlx_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output aluop_t     aluop,
  output s2op_t      s2op,
  output logic       legal
);

  always_comb begin
    aluop = ALU_ADD;
    s2op  = S2_RT;
    legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  aluop = ALU_ADD;
          FN_SUB:  aluop = ALU_SUB;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_XOR:  aluop = ALU_XOR;
          FN_SLL:  aluop = ALU_SLL;
          FN_SRL:  aluop = ALU_SRL;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: s2op = S2_SIMM;
      OP_SUBI: begin
        aluop = ALU_SUB;
        s2op  = S2_SIMM;
      end
      OP_BEQZ, OP_BNEZ: begin
        aluop = ALU_CMP;
        s2op  = S2_ZERO;
      end
      OP_J: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/dlx_ctrl_fsm.sv
// Multi-cycle DLX control FSM: fetch/decode/execute/memory/writeback sequencing.
// Define DLX_CTRL_TRAP_EN to make TRAP and illegal encodings halt the machine.
module dlx_ctrl_fsm
  import dlx_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int S2OP_W  = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        instr,
  input  logic               Zflag,
  input  logic               mem_ack,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [S2OP_W-1:0]  s2op,
  output logic               mem_req,
  output logic               mem_we,
  output logic               addr_sel,
  output logic               ir_load,
  output logic               pc_load,
  output logic               pc_sel,
  output logic               reg_we,
  output logic               wb_sel,
  output logic               rd_sel,
  output logic [2:0]         state,
  output logic               halted
);

  state_t     state_q;
  state_t     state_d;
  aluop_t     dec_aluop;
  s2op_t      dec_s2op;
  logic       dec_legal;
  logic [5:0] opcode;
  logic       branch_taken;
  logic       unused_instr_bits;

  assign opcode            = instr[31:26];
  assign unused_instr_bits = ^instr[25:6];
  assign branch_taken      = ((opcode == OP_BEQZ) && Zflag) ||
                             ((opcode == OP_BNEZ) && !Zflag);

  dlx_alu_decode u_decode (
    .opcode (opcode),
    .func   (instr[5:0]),
    .aluop  (dec_aluop),
    .s2op   (dec_s2op),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_ack) state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_legal) state_d = ST_EXECUTE;
`ifdef DLX_CTRL_TRAP_EN
        else           state_d = ST_HALT;
`else
        else           state_d = ST_FETCH;
`endif
      end
      ST_EXECUTE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW))
          state_d = ST_MEMORY;
        else if ((opcode == OP_BEQZ) || (opcode == OP_BNEZ) || (opcode == OP_J))
          state_d = ST_FETCH;
        else
          state_d = ST_WRITEBACK;
      end
      ST_MEMORY: begin
        if (mem_ack) state_d = (opcode == OP_SW) ? ST_FETCH : ST_WRITEBACK;
      end
      ST_WRITEBACK: state_d = ST_FETCH;
`ifdef DLX_CTRL_TRAP_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  // ALU controls follow the IR decode from EXECUTE through WRITEBACK; reset forces all low.
  always_comb begin
    ALUop    = '0;
    s2op     = '0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_load  = 1'b0;
    pc_load  = 1'b0;
    pc_sel   = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = 1'b0;
    rd_sel   = 1'b0;
    if (reset_n) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_load = mem_ack;
          pc_load = mem_ack;
        end
        ST_EXECUTE: begin
          ALUop = ALUOP_W'(dec_aluop);
          s2op  = S2OP_W'(dec_s2op);
          if ((opcode == OP_J) || branch_taken) begin
            pc_load = 1'b1;
            pc_sel  = 1'b1;
          end
        end
        ST_MEMORY: begin
          ALUop    = ALUOP_W'(dec_aluop);
          s2op     = S2OP_W'(dec_s2op);
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == OP_SW);
        end
        ST_WRITEBACK: begin
          ALUop  = ALUOP_W'(dec_aluop);
          s2op   = S2OP_W'(dec_s2op);
          reg_we = 1'b1;
          wb_sel = (opcode == OP_LW);
          rd_sel = (opcode != OP_RTYPE);
        end
        default: ;
      endcase
    end
  end

  assign state = reset_n ? state_q : ST_FETCH;

`ifdef DLX_CTRL_TRAP_EN
  logic halted_q;

  always_ff @(posedge clk) begin
    if (!reset_n)                halted_q <= 1'b0;
    else if (state_d == ST_HALT) halted_q <= 1'b1;
  end

  assign halted = reset_n & halted_q;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_dlx_ctrl_fsm.sv
// Directed scoreboard bench for dlx_ctrl_fsm: one expected output vector per cycle.
module tb_dlx_ctrl_fsm;

  localparam logic [8:0] NONE = 9'h000;
  localparam logic [8:0] REQ  = 9'h100;
  localparam logic [8:0] WE   = 9'h080;
  localparam logic [8:0] ADR  = 9'h040;
  localparam logic [8:0] IRL  = 9'h020;
  localparam logic [8:0] PCL  = 9'h010;
  localparam logic [8:0] PCS  = 9'h008;
  localparam logic [8:0] RWE  = 9'h004;
  localparam logic [8:0] WBS  = 9'h002;
  localparam logic [8:0] RDS  = 9'h001;

  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, SH = 3'd5;

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_SLL  = 32'h0022_1804;
  localparam logic [31:0] I_BEQZ = 32'h1020_0010;
  localparam logic [31:0] I_BNEZ = 32'h1420_0010;
  localparam logic [31:0] I_LW   = 32'h8C22_0004;
  localparam logic [31:0] I_SW   = 32'hAC22_0004;
  localparam logic [31:0] I_SUBI = 32'h2822_0005;
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;

  logic        clk = 1'b1;
  logic        reset_n;
  logic [31:0] instr;
  logic        Zflag;
  logic        mem_ack;
  logic [4:0]  ALUop;
  logic [2:0]  s2op;
  logic        mem_req, mem_we, addr_sel, ir_load, pc_load, pc_sel;
  logic        reg_we, wb_sel, rd_sel, halted;
  logic [2:0]  state;
  logic [20:0] observed;

  typedef struct {
    string       tag;
    logic [20:0] expv;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  dlx_ctrl_fsm dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .instr    (instr),
    .Zflag    (Zflag),
    .mem_ack  (mem_ack),
    .ALUop    (ALUop),
    .s2op     (s2op),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .addr_sel (addr_sel),
    .ir_load  (ir_load),
    .pc_load  (pc_load),
    .pc_sel   (pc_sel),
    .reg_we   (reg_we),
    .wb_sel   (wb_sel),
    .rd_sel   (rd_sel),
    .state    (state),
    .halted   (halted)
  );

  assign observed = {ALUop, s2op, mem_req, mem_we, addr_sel, ir_load, pc_load,
                     pc_sel, reg_we, wb_sel, rd_sel, state, halted};

  function automatic logic [20:0] ev(input logic [4:0] a, input logic [2:0] s,
                                     input logic [8:0] sb, input logic [2:0] st,
                                     input logic h);
    return {a, s, sb, st, h};
  endfunction

  task automatic applyStimulus(input logic rst, input logic [31:0] ins, input logic z,
                               input logic ack, input logic [20:0] expv, input string tag);
    sb_t item;
    reset_n   = rst;
    instr     = ins;
    Zflag     = z;
    mem_ack   = ack;
    item.tag  = tag;
    item.expv = expv;
    sb_q.push_back(item);
  endtask

  task automatic checkOutput();
    sb_t item;
    item = sb_q.pop_front();
    checks++;
    assert (observed === item.expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", item.tag, observed, item.expv);
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] ins, input logic z,
                      input logic ack, input logic [20:0] expv, input string tag);
    applyStimulus(rst, ins, z, ack, expv, tag);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting dlx_ctrl_fsm bench");
    // Reset held three cycles with ack high: everything must stay low
    step(0, I_ADD, 0, 1, ev(0, 0, NONE, SF, 0), "reset_c1");
    step(0, I_ADD, 0, 1, ev(0, 0, NONE, SF, 0), "reset_c2");
    step(0, I_ADD, 0, 1, ev(0, 0, NONE, SF, 0), "reset_c3");

    // ADD r3,r1,r2 with zero-wait fetch: 4 cycles
    step(1, I_ADD, 0, 1, ev(0, 0, REQ | IRL | PCL, SF, 0), "add_fetch");
    step(1, I_ADD, 0, 0, ev(0, 0, NONE, SD, 0), "add_decode");
    step(1, I_ADD, 0, 0, ev(5'b00000, 3'b000, NONE, SE, 0), "add_execute");
    step(1, I_ADD, 0, 0, ev(5'b00000, 3'b000, RWE, SW, 0), "add_writeback");

    // BEQZ taken, with one fetch wait cycle
    step(1, I_BEQZ, 1, 0, ev(0, 0, REQ, SF, 0), "beqz_fetch_wait");
    step(1, I_BEQZ, 1, 1, ev(0, 0, REQ | IRL | PCL, SF, 0), "beqz_fetch");
    step(1, I_BEQZ, 1, 0, ev(0, 0, NONE, SD, 0), "beqz_decode");
    step(1, I_BEQZ, 1, 0, ev(5'b10000, 3'b001, PCL | PCS, SE, 0), "beqz_taken");

    // BEQZ not taken
    step(1, I_BEQZ, 0, 1, ev(0, 0, REQ | IRL | PCL, SF, 0), "beqz_nt_fetch");
    step(1, I_BEQZ, 0, 0, ev(0, 0, NONE, SD, 0), "beqz_nt_decode");
    step(1, I_BEQZ, 0, 0, ev(5'b10000, 3'b001, NONE, SE, 0), "beqz_not_taken");

    // BNEZ taken when Z is clear
    step(1, I_BNEZ, 0, 1, ev(0, 0, REQ | IRL | PCL, SF, 0), "bnez_fetch");
    step(1, I_BNEZ, 0, 0, ev(0, 0, NONE, SD, 0), "bnez_decode");
    step(1, I_BNEZ, 0, 0, ev(5'b10000, 3'b001, PCL | PCS, SE, 0), "bnez_taken");

    // LW with ack ignored in DECODE/EXECUTE and two MEMORY wait cycles: 7 cycles
    step(1, I_LW, 0, 1, ev(0, 0, REQ | IRL | PCL, SF, 0), "lw_fetch");
    step(1, I_LW, 0, 1, ev(0, 0, NONE, SD, 0), "lw_decode_ack_ignored");
    step(1, I_LW, 0, 1, ev(5'b00000, 3'b011, NONE, SE, 0), "lw_execute_ack_ignored");
    step(1, I_LW, 0, 0, ev(5'b00000, 3'b011, REQ | ADR, SM, 0), "lw_mem_wait1");
    step(1, I_LW, 0, 0, ev(5'b00000, 3'b011, REQ | ADR, SM, 0), "lw_mem_wait2");
    step(1, I_LW, 0, 1, ev(5'b00000, 3'b011, REQ | ADR, SM, 0), "lw_mem_ack");
    step(1, I_LW, 0, 0, ev(5'b00000, 3'b011, RWE | WBS | RDS, SW, 0), "lw_writeback");

    // SW aborted by reset during the MEMORY wait
    step(1, I_SW, 0, 1, ev(0, 0, REQ | IRL | PCL, SF, 0), "sw_fetch");
    step(1, I_SW, 0, 0, ev(0, 0, NONE, SD, 0), "sw_decode");
    step(1, I_SW, 0, 0, ev(5'b00000, 3'b011, NONE, SE, 0), "sw_execute");
    step(1, I_SW, 0, 0, ev(5'b00000, 3'b011, REQ | WE | ADR, SM, 0), "sw_mem_wait");
    step(0, I_SW, 0, 0, ev(0, 0, NONE, SF, 0), "sw_reset_abort");

    // Fetch restarts after release; SUBI follows
    step(1, I_SUBI, 0, 0, ev(0, 0, REQ, SF, 0), "post_reset_fetch");
    step(1, I_SUBI, 0, 1, ev(0, 0, REQ | IRL | PCL, SF, 0), "subi_fetch");
    step(1, I_SUBI, 0, 0, ev(0, 0, NONE, SD, 0), "subi_decode");
    step(1, I_SUBI, 0, 0, ev(5'b00001, 3'b011, NONE, SE, 0), "subi_execute");
    step(1, I_SUBI, 0, 0, ev(5'b00001, 3'b011, RWE | RDS, SW, 0), "subi_writeback");

    // J: 3 cycles, unconditional target load
    step(1, I_J, 0, 1, ev(0, 0, REQ | IRL | PCL, SF, 0), "j_fetch");
    step(1, I_J, 0, 0, ev(0, 0, NONE, SD, 0), "j_decode");
    step(1, I_J, 0, 0, ev(0, 0, PCL | PCS, SE, 0), "j_execute");

    // R-type SLL
    step(1, I_SLL, 0, 1, ev(0, 0, REQ | IRL | PCL, SF, 0), "sll_fetch");
    step(1, I_SLL, 0, 0, ev(0, 0, NONE, SD, 0), "sll_decode");
    step(1, I_SLL, 0, 0, ev(5'b00101, 3'b000, NONE, SE, 0), "sll_execute");
    step(1, I_SLL, 0, 0, ev(5'b00101, 3'b000, RWE, SW, 0), "sll_writeback");

    // Illegal opcode 0x3F
    step(1, I_BAD, 0, 1, ev(0, 0, REQ | IRL | PCL, SF, 0), "bad_fetch");
    step(1, I_BAD, 0, 0, ev(0, 0, NONE, SD, 0), "bad_decode");
`ifdef DLX_CTRL_TRAP_EN
    step(1, I_BAD, 0, 1, ev(0, 0, NONE, SH, 1), "halt_c1");
    step(1, I_BAD, 0, 1, ev(0, 0, NONE, SH, 1), "halt_c2");
    step(1, I_ADD, 1, 1, ev(0, 0, NONE, SH, 1), "halt_c3");
`else
    step(1, I_BAD, 0, 0, ev(0, 0, REQ, SF, 0), "bad_nop_refetch");
`endif
    step(0, I_ADD, 0, 0, ev(0, 0, NONE, SF, 0), "final_reset");
    step(1, I_ADD, 0, 0, ev(0, 0, REQ, SF, 0), "final_release_fetch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dlx_ctrl_fsm.md
# dlx_ctrl_fsm

Multi-cycle control unit for the non-pipelined DLX. It sequences fetch/decode/execute/memory/writeback and drives the DLX_ALU control inputs (`ALUop`, `s2op`). It consumes the ALU's `Zflag` to resolve branches, and it drives the register-file, PC and memory-handshake strobes. It sits between the instruction register and the datapath.

## Interface
- `ALUOP_W`, default 5: width of `ALUop`.
- `S2OP_W`, default 3: width of `s2op`.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `instr` in 32: current IR contents. Bits [31:26] are the opcode; bits [5:0] are the R-type func field.
- `Zflag` in 1: zero flag from DLX_ALU.
- `mem_ack` in 1: memory completed the current request.
- `ALUop` out 5: ALU operation.
- `s2op` out 3: second-operand select.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write.
- `addr_sel` out 1: memory address source. 0 = PC, 1 = ALU result.
- `ir_load` out 1: load the IR.
- `pc_load` out 1: load the PC.
- `pc_sel` out 1: PC source. 0 = PC+4, 1 = branch/jump target.
- `reg_we` out 1: register-file write.
- `wb_sel` out 1: writeback source. 0 = ALU, 1 = memory.
- `rd_sel` out 1: destination field. 0 = rd [15:11], 1 = rt [20:16].
- `state` out 3: current state, for debug.
- `halted` out 1: sticky halt indication.

## Operation
- ALUop codes:
  - ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLL 00101, SRL 00110.
  - CMP 10000: s1−s2, used to set `Zflag`.
- s2op codes: 000 = register rt, 001 = constant 0, 011 = sign-extended imm16, 100 = zero-extended imm16.
- Supported opcodes:
  - R-type 0x00. Func codes 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x04 sll, 0x06 srl.
  - ADDI 0x08, SUBI 0x0A, LW 0x23, SW 0x2B, BEQZ 0x04, BNEZ 0x05, J 0x02, TRAP 0x11.
- States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5.
- FETCH:
  - Assert `mem_req`, `addr_sel`=0, and hold them until `mem_ack`.
  - In the `mem_ack` cycle, pulse `ir_load` and `pc_load` with `pc_sel`=0, then go to DECODE.
- DECODE: one cycle, no strobes.
  - J goes to EXECUTE.
  - TRAP and illegal encodings: see Configuration.
- EXECUTE: drive `ALUop`/`s2op` per opcode.
  - R-type: func→ALUop, s2op=000.
  - ADDI/LW/SW: ADD, s2op=011.
  - SUBI: SUB, s2op=011.
  - BEQZ/BNEZ: CMP, s2op=001. Sample `Zflag` combinationally this cycle. If taken (BEQZ&Z or BNEZ&!Z), `pc_load`=1 and `pc_sel`=1. Next state is FETCH.
  - J: `pc_load`=1, `pc_sel`=1, then FETCH.
  - LW/SW go to MEMORY. All other instructions go to WRITEBACK.
- MEMORY:
  - `mem_req`=1, `addr_sel`=1, `mem_we`=1 for SW. Hold until `mem_ack`.
  - SW then goes to FETCH; LW goes to WRITEBACK.
- WRITEBACK: `reg_we`=1 for exactly one cycle, then FETCH.
  - `wb_sel`=1 for LW, otherwise 0.
  - `rd_sel`=0 for R-type, otherwise 1.
- `ALUop`/`s2op` are held with their EXECUTE values through MEMORY and WRITEBACK. In all other states they are 00000/000.

## Timing
- Reset (`reset_n` low at a rising edge):
  - State becomes FETCH and `halted` becomes 0.
  - While `reset_n` is low, every output is forced to 0, including `mem_req`.
  - `mem_req` rises in the first cycle after release.
- All outputs are Moore decodes of state and `instr`. The only exceptions are `ir_load`/`pc_load`, which qualify with `mem_ack`, and branch `pc_load`, which qualifies with `Zflag`.
- Cycle counts with zero-wait memory (ack in the request cycle):
  - R-type / ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch / J: 3 cycles.
- Each wait cycle adds one cycle. `mem_ack` outside FETCH/MEMORY is ignored.
- Reset mid-operation (for example during a pending MEMORY request) aborts the access. `mem_req` drops in the reset cycle and no `reg_we` occurs.
- In HALT, all strobes stay 0 and `halted`=1 until reset.

## Configuration
- `DLX_CTRL_TRAP_EN` defined:
  - TRAP and any unsupported opcode/func go DECODE→HALT.
  - HALT is terminal and `halted` sets.
- `DLX_CTRL_TRAP_EN` undefined:
  - TRAP and illegal encodings are NOPs: DECODE→FETCH, no strobes.
  - HALT is unreachable and `halted` is tied to 0.

## Structure
- The shared package `dlx_pkg` holds:
  - ALUop and s2op encodings.
  - Opcode and func constants.
  - The state enum.
- DLX_ALU must import the same ALUop/s2op constants from `dlx_pkg`.
- One sub-module, `dlx_alu_decode`: purely combinational mapping of opcode/func to {ALUop, s2op, legal}. The FSM owns all sequencing.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset; `mem_req`=1 in the first cycle after release with `state`=0.
- `instr`=ADD r3,r1,r2 (0x00221820), ack immediate:
  - EXECUTE shows `ALUop`=00000, `s2op`=000.
  - WRITEBACK shows `reg_we`=1, `rd_sel`=0.
  - Total 4 cycles.
- BEQZ with `Zflag`=1 → EXECUTE `ALUop`=10000, `s2op`=001, `pc_load`=1, `pc_sel`=1. Repeat with `Zflag`=0 → no `pc_load` in EXECUTE.
- LW with `mem_ack` delayed 2 cycles in MEMORY:
  - `mem_req`/`addr_sel`=1 held 3 cycles.
  - Then `reg_we`=1 with `wb_sel`=1.
  - Total 7 cycles.
- SW with `reset_n` dropped during MEMORY wait → `mem_req`=0 that cycle and no `reg_we`; next fetch starts after release.
- Opcode 0x3F: with `DLX_CTRL_TRAP_EN`, `halted`=1 and `state`=5 held until reset; without it, the FSM returns to FETCH after DECODE.
